// File: rtl/beta_ex.sv
// beta_ex: Beta execute stage with ALU, kill/exception injection, EX/MEM register and a 32-cycle iterative divider.
module beta_ex #(
    parameter logic [31:0] NOP_INSTR = 32'h83FFF800,
    parameter logic [31:0] EXC_INSTR = 32'h77DF0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  irsrc,
    input  logic [31:0] pcin,
    input  logic [31:0] irin,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] d,
    output logic [31:0] pcout,
    output logic [31:0] irout,
    output logic [31:0] y,
    output logic [31:0] dout,
    output logic        busy,
    output logic [4:0]  byp_wa,
    output logic        byp_we,
    output logic        byp_valid
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, stateNext;
    logic [4:0]  count;
    logic [31:0] rem, quo, dvs, divPc, divIr, divD, aluY;
    logic [32:0] trial;
    logic        divNeg, divZero, isDiv, loadIdle;
    logic [5:0]  op, opOut;
    assign op       = irin[31:26];
    assign opOut    = irout[31:26];
    assign isDiv    = irsrc == 2'b00 && (op == 6'h23 || op == 6'h33);
    assign loadIdle = state == IDLE && !stall;
    assign busy     = state != IDLE;
    assign trial    = {rem, quo[31]} - {1'b0, dvs};
    always_comb begin
        aluY = '0;
        if (op[5]) begin
            case (op[3:0])
                4'h0: aluY = a + b;
                4'h1: aluY = a - b;
                4'h2: aluY = a * b;
                4'h4: aluY = {31'd0, a == b};
                4'h5: aluY = {31'd0, $signed(a) < $signed(b)};
                4'h6: aluY = {31'd0, $signed(a) <= $signed(b)};
                4'h8: aluY = a & b;
                4'h9: aluY = a | b;
                4'hA: aluY = a ^ b;
                4'hB: aluY = ~(a ^ b);
                4'hC: aluY = a << b[4:0];
                4'hD: aluY = a >> b[4:0];
                4'hE: aluY = $signed(a) >>> b[4:0];
                default: aluY = '0;
            endcase
        end else begin
            aluY = (op == 6'h18 || op == 6'h19 || op == 6'h1F) ? a + b :
                   (op == 6'h1B || op == 6'h1C || op == 6'h1D) ? pcin : '0;
        end
    end
    always_comb begin
        stateNext = state;
        stateNext = state == IDLE ? (isDiv && !stall ? RUN : IDLE) :
                    state == RUN  ? (count == 5'd31 ? DONE : RUN) :
                                    (stall ? DONE : IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            pcout <= '0;
            irout <= NOP_INSTR;
            y     <= '0;
            dout  <= '0;
        end else begin
            state <= stateNext;
            if (loadIdle) begin
                pcout <= pcin;
                dout  <= d;
                irout <= irsrc == 2'b00 ? (isDiv ? NOP_INSTR : irin) : irsrc == 2'b10 ? EXC_INSTR : NOP_INSTR;
                y     <= irsrc == 2'b00 ? (isDiv ? '0 : aluY) : irsrc == 2'b10 ? pcin : '0;
            end
            if (loadIdle && isDiv) begin
                rem     <= '0;
                quo     <= a[31] ? -a : a;
                dvs     <= b[31] ? -b : b;
                divNeg  <= a[31] ^ b[31];
                divZero <= b == '0;
                divPc   <= pcin;
                divIr   <= irin;
                divD    <= d;
                count   <= '0;
            end
            // restoring step: subtract divisor from the shifted partial remainder when it fits
            if (state == RUN) begin
                rem   <= trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
                quo   <= {quo[30:0], ~trial[32]};
                count <= count + 5'd1;
            end
            if (state == DONE && !stall) begin
                pcout <= divPc;
                irout <= divIr;
                dout  <= divD;
                y     <= divZero ? '1 : divNeg ? -quo : quo;
            end
        end
    end
    assign byp_wa    = irout[25:21];
    assign byp_we    = byp_wa != 5'd31 &&
                       ((opOut[5] && opOut[3:0] != 4'h7 && opOut[3:0] != 4'hF) ||
                        opOut == 6'h18 || opOut == 6'h1B || opOut == 6'h1C ||
                        opOut == 6'h1D || opOut == 6'h1F);
    assign byp_valid = !(opOut == 6'h18 || opOut == 6'h1F);
endmodule

// File: doc/beta_ex.md
Name: beta_ex

Overview:
- Execute stage of the pipelined Beta. Sits directly downstream of the register-fetch stage.
- Consumes that stage's pc, ir, operand a, operand b and store-data d. Applies kill/exception injection and evaluates the ALU.
- Registers pc, ir, result and store data into the EX/MEM pipeline register.
- Provides bypass information back to register fetch. Contains an iterative 32-cycle signed divider that raises busy to freeze upstream stages.

Parameters:
- NOP_INSTR, 32'h83FFF800, encoding of ADD(R31,R31,R31) injected as a bubble.
- EXC_INSTR, 32'h77DF0000, encoding of BNE(R31,0,XP) injected on exception.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- stall  input  1  downstream (MEM) stall; holds the EX/MEM register.
- irsrc  input  2  00 pass irin; 01 or 11 inject NOP_INSTR; 10 inject EXC_INSTR.
- pcin  input  32  PC+4 of the incoming instruction.
- irin  input  32  incoming instruction.
- a  input  32  bypassed operand A.
- b  input  32  bypassed operand B, or sign-extended literal.
- d  input  32  bypassed store data (Rc).
- pcout  output  32  registered pc.
- irout  output  32  registered instruction.
- y  output  32  registered ALU result.
- dout  output  32  registered store data.
- busy  output  1  divider active; upstream must hold. Registered: state != IDLE.
- byp_wa  output  5  destination register of irout, taken from irout[25:21].
- byp_we  output  1  irout writes a register and the destination is not R31.
- byp_valid  output  1  y holds the final writeback value. 0 for LD and LDR.

Behaviour:
- Reset (rst=1 at an edge):
  - irout=NOP_INSTR; pcout=0; y=0; dout=0; busy=0; divider state IDLE.
  - rst overrides stall, irsrc and any in-flight division.
- Effective instruction:
  - irsrc=00: irin.
  - irsrc=01 or 11: NOP_INSTR, y=0.
  - irsrc=10: EXC_INSTR, y=pcin (the saved XP).
  - pcin is always passed through.
- Register update: if stall=1, all outputs hold. If stall=0 and state IDLE, outputs load at the edge; single-cycle latency.
- ALU results, opcode 0x20-0x2E plus the constant forms +0x10:
  - ADD, SUB, MUL: modulo 2^32; MUL keeps the low 32 bits.
  - CMPEQ, CMPLT, CMPLE: signed compare, y = 32'h0 or 32'h1.
  - AND, OR, XOR, XNOR: bitwise.
  - SHL, SHR, SRA: shift amount is b[4:0].
  - LD, ST, LDR: y=a+b (LDR: RF supplies a=pc-relative base).
  - JMP, BEQ, BNE: y=pcin.
  - Any other opcode: y=0, byp_we=0.
  - dout=d in all cases.
- Divider FSM (DIV/DIVC with irsrc=00): states IDLE -> RUN -> DONE -> IDLE.
  - IDLE, stall=0, DIV present: capture a, b, pcin, ir; load NOP_INSTR into the output register as a bubble; count=0; go to RUN.
  - RUN: one quotient bit per cycle, restoring algorithm on magnitudes. count 0..31; after count 31 go to DONE. Counting continues regardless of stall.
  - DONE: once stall=0, load y=quotient with the captured pc/ir; go to IDLE.
  - busy=1 in RUN and DONE. Inputs are ignored while busy=1.
  - Minimum latency: accept edge E, result loaded at E+33, busy high for 33 cycles.
- Quotient rules:
  - Truncated toward zero; sign is sign(a) XOR sign(b).
  - Divide by zero gives 32'hFFFFFFFF.
  - 32'h80000000 / -1 gives 32'h80000000.
- irsrc=01, 10 or 11 applied to a DIV: inject as above, and the divider does not start.
- Bypass: derived from the registered irout, so they are valid in the same cycle as y.
  - byp_we=1 for ALU ops, LD, LDR, JMP, BEQ, BNE and EXC_INSTR, when rc!=31.
  - ST, NOP and unknown opcodes give byp_we=0.

Test Plan:
- Reset, then ADDC R1 with a=5, b=32'hFFFFFFFD -> next edge: y=2, byp_wa=1, byp_we=1, byp_valid=1.
- SRA with a=32'h80000000, b=4 -> y=32'hF8000000. SHR with the same operands -> y=32'h08000000.
- irsrc=10, pcin=32'h124, irin=LD -> irout=32'h77DF0000, y=32'h124, byp_wa=30, byp_valid=1.
- DIV a=-7, b=2, stall held 1 during cycles 20-40 -> busy=1 until stall drops; then y=32'hFFFFFFFD with the original pcout. A following ADD is accepted only after busy=0.
- DIV a=9, b=0 -> y=32'hFFFFFFFF at E+33. DIV a=32'h80000000, b=-1 -> y=32'h80000000.
- rst asserted at count=10 of a DIV -> next edge: busy=0, irout=NOP_INSTR, y=0. No quotient is ever produced.
